// File: rtl/led_sched_pkg.sv
// Shared FSM state codes, LED pattern codes and the round-robin pick used by led_sched.
package led_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  localparam logic [1:0] PAT_OFF   = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_SLOW  = 2'd2;
  localparam logic [1:0] PAT_FAST  = 2'd3;

  // First set request searching from last+1 upward (mod 4); last itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, first tick DIV clocks after reset.
module led_tick_gen #(
  parameter int DIV = 12000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  import led_sched_pkg::*;

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/led_sched.sv
// Four-requester LED owner scheduler: round-robin arbitration with a minimum hold time,
// driving the owner's latched solid/blink pattern onto the green or red LED.
module led_sched #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int HOLD_TICKS = 500,
  parameter int SLOW_HALF  = 500,
  parameter int FAST_HALF  = 125
) (
  input  logic       clk_12mhz,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] pattern,
  input  logic [3:0] color,
  output logic [3:0] grant,
  output logic       green_led,
  output logic       red_led,
  output logic       busy
);
  import led_sched_pkg::*;

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int HW     = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int HALF_M = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int PW     = (HALF_M > 1) ? $clog2(HALF_M) : 1;

  logic          tick;
  logic [1:0]    state, state_nx;
  logic [1:0]    last_owner, last_nx;
  logic [1:0]    pat_q, pat_nx;
  logic          col_q, col_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [PW-1:0] phase_cnt, phase_cnt_nx, half_m1;
  logic          phase_on, phase_on_nx;
  logic [3:0]    grant_nx;
  logic [1:0]    winner;
  logic          lvl;

  led_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk_12mhz),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    last_nx      = last_owner;
    pat_nx       = pat_q;
    col_nx       = col_q;
    hold_nx      = hold_cnt;
    phase_cnt_nx = phase_cnt;
    phase_on_nx  = phase_on;
    half_m1      = (pat_q == PAT_SLOW) ? PW'(SLOW_HALF - 1) : PW'(FAST_HALF - 1);
    winner       = rr_pick(req, last_owner);
    case (state)
      ST_IDLE: begin
        grant_nx = '0;
        if (|req) state_nx = ST_ARB;
      end
      ST_ARB: begin
        if (|req) begin
          state_nx     = ST_OWN;
          grant_nx     = 4'b0001 << winner;
          last_nx      = winner;
          pat_nx       = pattern[{winner, 1'b0} +: 2];
          col_nx       = color[winner];
          hold_nx      = '0;
          phase_cnt_nx = '0;
          phase_on_nx  = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (!req[last_owner]) begin
          state_nx = ST_ARB;
          grant_nx = '0;
        end else if (hold_cnt >= HW'(HOLD_TICKS) && |(req & ~grant)) begin
          // last_owner stays at the pre-empted owner, so it is searched last in ARB
          state_nx = ST_ARB;
          grant_nx = '0;
        end else if (tick) begin
          if (hold_cnt < HW'(HOLD_TICKS)) hold_nx = hold_cnt + HW'(1);
          if (pat_q == PAT_SLOW || pat_q == PAT_FAST) begin
            if (phase_cnt == half_m1) begin
              phase_cnt_nx = '0;
              phase_on_nx  = ~phase_on;
            end else begin
              phase_cnt_nx = phase_cnt + PW'(1);
            end
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase
    lvl = (state_nx == ST_OWN) &&
          ((pat_nx == PAT_SOLID) ||
           ((pat_nx == PAT_SLOW || pat_nx == PAT_FAST) && phase_on_nx));
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_owner <= 2'd3;
      pat_q      <= PAT_OFF;
      col_q      <= 1'b0;
      hold_cnt   <= '0;
      phase_cnt  <= '0;
      phase_on   <= 1'b0;
      green_led  <= 1'b0;
      red_led    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_owner <= last_nx;
      pat_q      <= pat_nx;
      col_q      <= col_nx;
      hold_cnt   <= hold_nx;
      phase_cnt  <= phase_cnt_nx;
      phase_on   <= phase_on_nx;
      green_led  <= lvl && !col_nx;
      red_led    <= lvl && col_nx;
      busy       <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_led_sched.sv
// Directed bench for led_sched with a 10-clock tick, hold of 4 ticks, slow half 3, fast half 1.
module tb_led_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] pattern;
  logic [3:0] color;
  logic [3:0] grant;
  logic       green_led;
  logic       red_led;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int ec;

  led_sched #(
    .CLK_HZ(1000), .TICK_HZ(100), .HOLD_TICKS(4), .SLOW_HALF(3), .FAST_HALF(1)
  ) dut (
    .clk_12mhz (clk),
    .rst_n     (rst_n),
    .req       (req),
    .pattern   (pattern),
    .color     (color),
    .grant     (grant),
    .green_led (green_led),
    .red_led   (red_led),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; ticks land on edges 10, 20, 30, ...
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  task automatic goto(input int n);
    while (ec < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; pattern = '0; color = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_green", green_led, 0);
    chk("rst_red", red_led, 0);
    chk("rst_busy", busy, 0);

    // Solid green for requester 0
    rst_n = 1'b1; req = 4'b0001; pattern = 8'h01; color = 4'b0000;
    goto(1);
    chk("arb_busy", busy, 1);
    chk("arb_grant", grant, 0);
    goto(2);
    chk("solid_grant", grant, 4'b0001);
    chk("solid_green", green_led, 1);
    chk("solid_red", red_led, 0);
    goto(22);
    chk("solid_hold_grant", grant, 4'b0001);
    chk("solid_hold_green", green_led, 1);

    // Drop, then re-grant straight out of ARB with slow blink on red
    req = 4'b0000;
    goto(23);
    chk("drop_grant", grant, 0);
    chk("drop_green", green_led, 0);
    chk("drop_busy", busy, 1);
    req = 4'b0001; pattern = 8'h02; color = 4'b0001;
    goto(24);
    chk("slow_grant", grant, 4'b0001);
    chk("slow_red_on", red_led, 1);
    goto(49);
    chk("slow_red_before", red_led, 1);
    goto(50);
    chk("slow_red_off", red_led, 0);
    chk("slow_green", green_led, 0);
    // Changes while owning must not take effect
    pattern = 8'h01; color = 4'b0000;
    goto(79);
    chk("slow_red_still_off", red_led, 0);
    goto(80);
    chk("slow_red_on2", red_led, 1);
    chk("latched_green", green_led, 0);
    goto(110);
    chk("latched_red_off", red_led, 0);
    goto(140);
    chk("latched_red_on3", red_led, 1);

    // Asynchronous reset mid-ownership
    #1 rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_red", red_led, 0);
    chk("async_busy", busy, 0);
    req = 4'b1111; pattern = 8'h55; color = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    goto(2);
    chk("post_rst_grant", grant, 4'b0001);
    chk("post_rst_green", green_led, 1);

    // Contention between 0 and 1 with hold of 4 ticks
    req = 4'b0011;
    goto(40);
    chk("hold0_grant", grant, 4'b0001);
    goto(41);
    chk("preempt0_grant", grant, 0);
    chk("preempt0_green", green_led, 0);
    chk("preempt0_busy", busy, 1);
    goto(42);
    chk("own1_grant", grant, 4'b0010);
    goto(80);
    chk("hold1_grant", grant, 4'b0010);
    goto(81);
    chk("preempt1_grant", grant, 0);
    goto(82);
    chk("back0_grant", grant, 4'b0001);
    chk("back0_green", green_led, 1);

    // Owner 0 leaves, 2 wins; then 2 drops with 3 still requesting
    req = 4'b1100;
    goto(83);
    chk("leave0_grant", grant, 0);
    goto(84);
    chk("own2_grant", grant, 4'b0100);
    req = 4'b1000; color = 4'b1000;
    goto(85);
    chk("drop2_grant", grant, 0);
    chk("drop2_green", green_led, 0);
    chk("drop2_red", red_led, 0);
    goto(86);
    chk("own3_grant", grant, 4'b1000);
    chk("own3_red", red_led, 1);
    chk("own3_green", green_led, 0);

    // Fast blink, grant landing on a tick edge
    req = 4'b0000;
    goto(88);
    chk("idle_busy", busy, 0);
    req = 4'b1000; pattern = 8'hC0; color = 4'b1000;
    goto(90);
    chk("fast_grant", grant, 4'b1000);
    chk("fast_red_on", red_led, 1);
    goto(99);
    chk("fast_red_hold", red_led, 1);
    goto(100);
    chk("fast_red_off", red_led, 0);
    goto(110);
    chk("fast_red_on2", red_led, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
